// File: rtl/spi_slave_io.sv
// SPI mode-0 slave with a CPU register interface: status/control at $0, data at $1.
// SPI inputs are resynchronised to clk; all shifting happens on detected sck edges.
module spi_slave_io (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       ss_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e     state_q;
  logic       ss_s1_q, ss_s2_q, ss_prev_q;
  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [7:0] rx_shift_q, rx_data_q, tx_shift_q, tx_buf_q;
  logic [2:0] bit_cnt_q;
  logic       rdy_q, ovr_q, txe_q, ie_q;

  logic       sck_rise, sck_fall, ss_fall, ss_rise;
  logic       rd, wr_reg0, wr_reg1, rd_reg1;
  logic       byte_done, load;
  logic [7:0] load_byte, status;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      ss_prev_q  <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
    end else begin
      ss_s1_q    <= ss_n;
      ss_s2_q    <= ss_s1_q;
      ss_prev_q  <= ss_s2_q;
      sck_s1_q   <= sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      mosi_s1_q  <= mosi;
      mosi_s2_q  <= mosi_s1_q;
    end
  end

  always_comb begin
    sck_rise  = sck_s2_q & ~sck_prev_q;
    sck_fall  = ~sck_s2_q & sck_prev_q;
    ss_fall   = ~ss_s2_q & ss_prev_q;
    ss_rise   = ss_s2_q & ~ss_prev_q;
    rd        = cs & rw;
    wr_reg0   = cs & ~rw & (AD == 3'd0);
    wr_reg1   = cs & ~rw & (AD == 3'd1);
    rd_reg1   = rd & (AD == 3'd1);
    // A deselect takes priority over any sck edge seen in the same cycle.
    byte_done = (state_q == StActive) & ~ss_rise & sck_rise & (bit_cnt_q == 3'd7);
    load      = ((state_q == StIdle) & ss_fall) | byte_done;
    load_byte = txe_q ? 8'hFF : tx_buf_q;
    status    = {rdy_q, ovr_q, txe_q, (state_q == StActive), 3'b000, ie_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      DO         <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'hFF;
      tx_shift_q <= 8'hFF;
      tx_buf_q   <= 8'hFF;
      bit_cnt_q  <= 3'd0;
      rdy_q      <= 1'b0;
      ovr_q      <= 1'b0;
      txe_q      <= 1'b1;
      ie_q       <= 1'b0;
    end else begin
      if (rd) begin
        unique case (AD)
          3'd0:    DO <= status;
          3'd1:    DO <= rx_data_q;
          default: DO <= 8'h00;
        endcase
      end

      if (wr_reg0) ie_q <= DI[0];
      if (wr_reg0 && DI[6]) ovr_q <= 1'b0;

      // A completing byte beats a concurrent $1 read: RDY stays set, no overrun.
      if (byte_done) begin
        rx_data_q <= {rx_shift_q[6:0], mosi_s2_q};
        rdy_q     <= 1'b1;
        if (rdy_q && !rd_reg1) ovr_q <= 1'b1;
      end else if (rd_reg1) begin
        rdy_q <= 1'b0;
      end

      // Load sees pre-write tx_buf/TXE; a same-cycle $1 write stays pending.
      if (load) begin
        tx_shift_q <= load_byte;
        txe_q      <= 1'b1;
      end
      if (wr_reg1) begin
        tx_buf_q <= DI;
        txe_q    <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q   <= StActive;
            bit_cnt_q <= 3'd0;
          end
        end
        StActive: begin
          if (ss_rise) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
          end else if (sck_rise) begin
            rx_shift_q <= {rx_shift_q[6:0], mosi_s2_q};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
          end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
            tx_shift_q <= {tx_shift_q[6:0], 1'b1};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign miso    = (state_q == StActive) ? tx_shift_q[7] : 1'b1;
  assign miso_oe = (state_q == StActive);
  assign irq     = ie_q & rdy_q;

endmodule

// File: tb/tb_spi_slave_io.sv
// Scoreboard bench for spi_slave_io: expected DO bytes and MISO bytes are queued by the
// stimulus and popped by independent monitors.
module tb_spi_slave_io;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b0;
  logic       cs = 1'b0;
  logic       irq;
  logic       ss_n = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;

  int errors = 0;
  int checks = 0;
  logic [7:0] do_q[$];
  logic [7:0] miso_q[$];
  logic       rd_seen = 1'b0;

  spi_slave_io dut (
    .clk     (clk),
    .rst     (rst),
    .AD      (AD),
    .DI      (DI),
    .DO      (DO),
    .rw      (rw),
    .cs      (cs),
    .irq     (irq),
    .ss_n    (ss_n),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // DO monitor: a read sampled on a rising edge presents its data by the next falling edge.
  initial forever begin
    @(posedge clk);
    rd_seen = cs & rw;
  end

  initial forever begin
    @(negedge clk);
    if (rd_seen) begin
      if (do_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL DO unexpected: got %0h want none", DO);
      end else begin
        check("DO", {24'h0, DO}, {24'h0, do_q.pop_front()});
      end
    end
  end

  // MISO monitor: master samples on sck rising; a deselect discards a partial byte.
  initial begin
    int mcnt;
    logic [7:0] mbits;
    mcnt = 0;
    mbits = 8'h00;
    forever begin
      @(posedge sck or posedge ss_n);
      if (ss_n) begin
        mcnt = 0;
      end else begin
        mbits = {mbits[6:0], miso};
        mcnt++;
        if (mcnt == 8) begin
          mcnt = 0;
          check("MISO_OE", {31'h0, miso_oe}, 32'h1);
          if (miso_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL MISO unexpected: got %0h want none", mbits);
          end else begin
            check("MISO", {24'h0, mbits}, {24'h0, miso_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] a, input logic [7:0] exp);
    do_q.push_back(exp);
    cs = 1'b1; rw = 1'b1; AD = a;
    clks(1);
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    clks(1);
    cs = 1'b0;
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    clks(6);
  endtask

  task automatic ss_high();
    clks(2);
    ss_n = 1'b1;
    clks(6);
  endtask

  // mode 1: $1 read lands on the completion edge (wd = expected DO);
  // mode 2: $1 write of wd lands on the completion/reload edge.
  task automatic send_byte(input logic [7:0] m, input logic [7:0] exp_miso, input int mode,
                           input logic [7:0] wd, input int nbits);
    if (nbits == 8) miso_q.push_back(exp_miso);
    for (int i = 0; i < nbits; i++) begin
      mosi = m[7-i];
      clks(4);
      sck = 1'b1;
      clks(2);
      if (i == 7 && mode == 1) begin
        do_q.push_back(wd);
        cs = 1'b1; rw = 1'b1; AD = 3'd1;
      end else if (i == 7 && mode == 2) begin
        cs = 1'b1; rw = 1'b0; AD = 3'd1; DI = wd;
      end
      clks(1);
      cs = 1'b0; rw = 1'b0;
      clks(1);
      sck = 1'b0;
    end
  endtask

  initial begin
    clks(2);
    #1;
    check("rst DO", {24'h0, DO}, 32'h0);
    check("rst miso", {31'h0, miso}, 32'h1);
    check("rst miso_oe", {31'h0, miso_oe}, 32'h0);
    check("rst irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    clks(2);
    cpu_read(3'd0, 8'h20);
    cpu_read(3'd1, 8'hFF);
    cpu_write(3'd2, 8'hFF);
    cpu_read(3'd5, 8'h00);
    cpu_read(3'd0, 8'h20);

    // Basic transfer: A5 out, 3C in.
    cpu_write(3'd1, 8'hA5);
    cpu_read(3'd0, 8'h00);
    ss_low();
    check("sel miso_oe", {31'h0, miso_oe}, 32'h1);
    cpu_read(3'd0, 8'h30);
    send_byte(8'h3C, 8'hA5, 0, 8'h00, 8);
    ss_high();
    cpu_read(3'd0, 8'hA0);
    cpu_read(3'd1, 8'h3C);
    cpu_read(3'd0, 8'h20);

    // Two bytes without TX data or reads: all ones out, overrun.
    ss_low();
    send_byte(8'h11, 8'hFF, 0, 8'h00, 8);
    send_byte(8'h22, 8'hFF, 0, 8'h00, 8);
    ss_high();
    cpu_read(3'd0, 8'hE0);
    cpu_write(3'd0, 8'h40);
    cpu_read(3'd0, 8'hA0);
    cpu_read(3'd1, 8'h22);

    // Interrupt.
    cpu_write(3'd0, 8'h01);
    check("irq idle", {31'h0, irq}, 32'h0);
    ss_low();
    send_byte(8'h5A, 8'hFF, 0, 8'h00, 8);
    check("irq set", {31'h0, irq}, 32'h1);
    ss_high();
    cpu_read(3'd0, 8'hA1);
    check("irq before read", {31'h0, irq}, 32'h1);
    cpu_read(3'd1, 8'h5A);
    check("irq after read", {31'h0, irq}, 32'h0);
    cpu_write(3'd0, 8'h00);

    // Abort after 5 bits, then a clean byte.
    ss_low();
    send_byte(8'hFF, 8'hFF, 0, 8'h00, 5);
    ss_high();
    check("abort miso_oe", {31'h0, miso_oe}, 32'h0);
    check("abort miso", {31'h0, miso}, 32'h1);
    cpu_read(3'd0, 8'h20);
    ss_low();
    send_byte(8'hC3, 8'hFF, 0, 8'h00, 8);
    ss_high();
    cpu_read(3'd1, 8'hC3);

    // Completion coincident with a $1 read.
    ss_low();
    send_byte(8'h81, 8'hFF, 0, 8'h00, 8);
    send_byte(8'h7E, 8'hFF, 1, 8'h81, 8);
    ss_high();
    cpu_read(3'd0, 8'hA0);
    cpu_read(3'd1, 8'h7E);

    // $1 write coincident with the reload.
    ss_low();
    send_byte(8'h01, 8'hFF, 2, 8'h96, 8);
    cpu_read(3'd0, 8'h90);
    send_byte(8'h02, 8'hFF, 0, 8'h00, 8);
    send_byte(8'h03, 8'h96, 0, 8'h00, 8);
    ss_high();
    cpu_read(3'd0, 8'hE0);
    cpu_write(3'd0, 8'h40);
    cpu_read(3'd1, 8'h03);

    // Reset mid-transfer at bit 4.
    cpu_write(3'd1, 8'h69);
    cpu_write(3'd0, 8'h01);
    ss_low();
    send_byte(8'hAA, 8'hFF, 0, 8'h00, 4);
    rst = 1'b0;
    #1;
    check("mid rst DO", {24'h0, DO}, 32'h0);
    check("mid rst miso", {31'h0, miso}, 32'h1);
    check("mid rst miso_oe", {31'h0, miso_oe}, 32'h0);
    check("mid rst irq", {31'h0, irq}, 32'h0);
    ss_n = 1'b1;
    clks(3);
    rst = 1'b1;
    clks(3);
    cpu_read(3'd0, 8'h20);
    cpu_read(3'd1, 8'hFF);
    ss_low();
    send_byte(8'hE7, 8'hFF, 0, 8'h00, 8);
    ss_high();
    cpu_read(3'd1, 8'hE7);

    clks(4);
    check("DO queue drained", do_q.size(), 32'h0);
    check("MISO queue drained", miso_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
